// File: rtl/alu32_issue_ctrl_if.sv
// Bundles the command, ALU-drive, result and status signals of the ALU32 issue stage.
// The slave modport is the controller's view; the master modport is the environment's view.
interface alu32_issue_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [3:0]       cmd_op1;
    logic [31:0]      cmd_in0;
    logic [31:0]      cmd_in1;
    logic [TAG_W-1:0] cmd_tag;

    logic [3:0]       alu_op;
    logic [3:0]       alu_op1;
    logic [31:0]      alu_in0;
    logic [31:0]      alu_in1;
    logic [31:0]      alu_out;
    logic [31:0]      alu_out0;
    logic             alu_carryout;
    logic             alu_overflow;
    logic             alu_zero;
    logic             alu_n;

    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_lo;
    logic [31:0]      res_hi;
    logic [3:0]       res_flags;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;

    logic             busy;
    logic [CNT_W-1:0] fifo_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_op1, cmd_in0, cmd_in1, cmd_tag,
        output cmd_ready,
        output alu_op, alu_op1, alu_in0, alu_in1,
        input  alu_out, alu_out0, alu_carryout, alu_overflow, alu_zero, alu_n,
        output res_valid, res_lo, res_hi, res_flags, res_tag, res_err,
        input  res_ready,
        output busy, fifo_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_op1, cmd_in0, cmd_in1, cmd_tag,
        input  cmd_ready,
        input  alu_op, alu_op1, alu_in0, alu_in1,
        output alu_out, alu_out0, alu_carryout, alu_overflow, alu_zero, alu_n,
        input  res_valid, res_lo, res_hi, res_flags, res_tag, res_err,
        output res_ready,
        input  busy, fifo_count
    );
endinterface

// File: rtl/alu32_issue_ctrl.sv
// Issue stage ahead of the combinational ALU32: queues commands, holds each one on the
// ALU inputs for an op-dependent settle time, then captures and presents the result.
module alu32_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 4,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu32_issue_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int LAT_W = $clog2(MUL_LAT + 1);

    typedef struct packed {
        logic [3:0]       op;
        logic [3:0]       op1;
        logic [31:0]      in0;
        logic [31:0]      in1;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_t           state_q;
    logic [LAT_W-1:0] cnt_q;
    logic [3:0]       aluOp_q, aluOp1_q;
    logic [31:0]      aluIn0_q, aluIn1_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;
    logic             resValid_q;
    logic [31:0]      resLo_q, resHi_q;
    logic [3:0]       resFlags_q;
    logic [TAG_W-1:0] resTag_q;
    logic             resErr_q;

    logic full, push, pop;
    cmd_t head;

    // A full FIFO refuses new commands even when the FSM pops in the same cycle.
    assign full = (count_q == CNT_W'(DEPTH));
    assign push = bus.cmd_valid && !full;
    assign pop  = (state_q == IDLE) && (count_q != '0);
    assign head = mem_q[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
        if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= '{op: bus.cmd_op, op1: bus.cmd_op1, in0: bus.cmd_in0,
                                      in1: bus.cmd_in1, tag: bus.cmd_tag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            aluOp_q    <= '0;
            aluOp1_q   <= '0;
            aluIn0_q   <= '0;
            aluIn1_q   <= '0;
            tag_q      <= '0;
            err_q      <= 1'b0;
            resValid_q <= 1'b0;
            resLo_q    <= '0;
            resHi_q    <= '0;
            resFlags_q <= '0;
            resTag_q   <= '0;
            resErr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        aluOp_q  <= head.op;
                        aluOp1_q <= head.op1;
                        aluIn0_q <= head.in0;
                        aluIn1_q <= head.in1;
                        tag_q    <= head.tag;
                        if (head.op > 4'b0011) begin
                            err_q <= 1'b1;
                            cnt_q <= '0;
                        end else begin
                            err_q <= 1'b0;
                            cnt_q <= (head.op == 4'b0011) ? LAT_W'(MUL_LAT - 1)
                                                          : LAT_W'(ALU_LAT - 1);
                        end
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - LAT_W'(1);
                    end else begin
                        // Illegal ops report an error with a zeroed payload.
                        resLo_q    <= err_q ? 32'h0 : bus.alu_out;
                        resHi_q    <= err_q ? 32'h0 : bus.alu_out0;
                        resFlags_q <= err_q ? 4'h0
                                            : {bus.alu_carryout, bus.alu_overflow,
                                               bus.alu_zero, bus.alu_n};
                        resTag_q   <= tag_q;
                        resErr_q   <= err_q;
                        resValid_q <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (bus.res_ready) begin
                        resValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = !full;
    assign bus.alu_op     = aluOp_q;
    assign bus.alu_op1    = aluOp1_q;
    assign bus.alu_in0    = aluIn0_q;
    assign bus.alu_in1    = aluIn1_q;
    assign bus.res_valid  = resValid_q;
    assign bus.res_lo     = resLo_q;
    assign bus.res_hi     = resHi_q;
    assign bus.res_flags  = resFlags_q;
    assign bus.res_tag    = resTag_q;
    assign bus.res_err    = resErr_q;
    assign bus.busy       = (state_q != IDLE) || (count_q != '0);
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_alu32_issue_ctrl.sv
// Scoreboard bench for alu32_issue_ctrl with a behavioural ALU32 stand-in closing the loop.
module tb_alu32_issue_ctrl;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  flags;
    } aluRes_t;

    typedef struct {
        aluRes_t    res;
        logic [3:0] tag;
        logic       err;
        int         pushCycle;
        int         expLat;
    } sbEntry_t;

    logic clk;
    logic rst_n;
    int   cycle;
    int   vectorCount;
    int   missCount;
    logic prevValid;
    logic pushDone;
    aluRes_t  aluR;
    sbEntry_t sbq[$];

    alu32_issue_ctrl_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) ifc ();

    alu32_issue_ctrl #(.DEPTH(DEPTH), .ALU_LAT(1), .MUL_LAT(4), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference ALU32: illegal groups produce deliberate garbage so zeroing is visible.
    function automatic aluRes_t aluModel(input logic [3:0] op, input logic [3:0] op1,
                                         input logic [31:0] a, input logic [31:0] b);
        aluRes_t     r;
        logic [32:0] s;
        logic [63:0] p;
        logic        c, v, z, n;
        r = '0; s = '0; p = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0000: begin
                if (op1[0]) begin
                    s = {1'b0, a} - {1'b0, b};
                    r.lo = s[31:0];
                    c = ~s[32];
                    v = (a[31] != b[31]) && (r.lo[31] != a[31]);
                end else begin
                    s = {1'b0, a} + {1'b0, b};
                    r.lo = s[31:0];
                    c = s[32];
                    v = (a[31] == b[31]) && (r.lo[31] != a[31]);
                end
            end
            4'b0001: begin
                case (op1[1:0])
                    2'd0:    r.lo = a << b[4:0];
                    2'd1:    r.lo = a >> b[4:0];
                    default: r.lo = $unsigned($signed(a) >>> b[4:0]);
                endcase
            end
            4'b0010: begin
                case (op1[1:0])
                    2'd0:    r.lo = a & b;
                    2'd1:    r.lo = a | b;
                    2'd2:    r.lo = a ^ b;
                    default: r.lo = ~(a | b);
                endcase
            end
            4'b0011: begin
                p = {32'h0, a} * {32'h0, b};
                r.lo = p[31:0];
                r.hi = p[63:32];
                v = (r.hi != 32'h0);
            end
            default: begin
                r.lo = a ^ b;
                r.hi = 32'hFFFF_FFFF;
                r.flags = 4'hF;
                return r;
            end
        endcase
        z = (op == 4'b0011) ? (p == 64'h0) : (r.lo == 32'h0);
        n = (op == 4'b0011) ? r.hi[31] : r.lo[31];
        r.flags = {c, v, z, n};
        return r;
    endfunction

    // The stand-in ALU reacts combinationally to whatever the controller drives.
    always_comb begin
        aluR = aluModel(ifc.alu_op, ifc.alu_op1, ifc.alu_in0, ifc.alu_in1);
        ifc.alu_out      = aluR.lo;
        ifc.alu_out0     = aluR.hi;
        ifc.alu_carryout = aluR.flags[3];
        ifc.alu_overflow = aluR.flags[2];
        ifc.alu_zero     = aluR.flags[1];
        ifc.alu_n        = aluR.flags[0];
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cycle);
        end
    endtask

    // Result monitor: samples on the falling edge, checks latency on the rising of
    // res_valid and the payload on each accepted result.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 1'b0;
        end else begin
            if (ifc.res_valid) begin
                if (sbq.size() == 0) begin
                    checkOutput("spuriousRes", 64'(ifc.res_valid), 64'(0));
                end else begin
                    if (!prevValid && sbq[0].expLat >= 0)
                        checkOutput("latency", 64'(cycle - sbq[0].pushCycle),
                                    64'(sbq[0].expLat));
                    if (ifc.res_ready) begin
                        sbEntry_t e;
                        e = sbq.pop_front();
                        checkOutput("resLo",    64'(ifc.res_lo),    64'(e.res.lo));
                        checkOutput("resHi",    64'(ifc.res_hi),    64'(e.res.hi));
                        checkOutput("resFlags", 64'(ifc.res_flags), 64'(e.res.flags));
                        checkOutput("resTag",   64'(ifc.res_tag),   64'(e.tag));
                        checkOutput("resErr",   64'(ifc.res_err),   64'(e.err));
                    end
                end
            end
            prevValid = ifc.res_valid;
        end
    end

    // Drives one command, waiting (bounded) for cmd_ready, and records its expectation.
    task automatic applyStimulus(input logic [3:0] op, input logic [3:0] op1,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] tag, input aluRes_t exp,
                                 input logic err, input int expLat);
        int waitCnt;
        waitCnt = 0;
        ifc.cmd_op    = op;
        ifc.cmd_op1   = op1;
        ifc.cmd_in0   = a;
        ifc.cmd_in1   = b;
        ifc.cmd_tag   = tag;
        ifc.cmd_valid = 1'b1;
        while (!ifc.cmd_ready && waitCnt < 200) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!ifc.cmd_ready) begin
            checkOutput("cmdReadyTimeout", 64'(ifc.cmd_ready), 64'(1));
            ifc.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        sbq.push_back('{res: exp, tag: tag, err: err, pushCycle: cycle, expLat: expLat});
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic applyModelCmd(input logic [3:0] op, input logic [3:0] op1,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] tag);
        aluRes_t e;
        logic    illegal;
        illegal = (op > 4'b0011);
        e = illegal ? aluRes_t'('0) : aluModel(op, op1, a, b);
        applyStimulus(op, op1, a, b, tag, e, illegal, -1);
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while ((sbq.size() != 0 || ifc.busy) && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("drainTimeout", 64'(sbq.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectorCount   = 0;
        missCount     = 0;
        cycle         = 0;
        pushDone      = 1'b0;
        rst_n         = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = '0;
        ifc.cmd_op1   = '0;
        ifc.cmd_in0   = '0;
        ifc.cmd_in1   = '0;
        ifc.cmd_tag   = '0;
        ifc.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        checkOutput("rstResValid",  64'(ifc.res_valid),  64'(0));
        checkOutput("rstFifoCount", 64'(ifc.fifo_count), 64'(0));
        checkOutput("rstBusy",      64'(ifc.busy),       64'(0));
        checkOutput("rstCmdReady",  64'(ifc.cmd_ready),  64'(1));
        checkOutput("rstAluOp",     64'(ifc.alu_op),     64'(0));
        checkOutput("rstAluIn0",    64'(ifc.alu_in0),    64'(0));
        checkOutput("rstResLo",     64'(ifc.res_lo),     64'(0));
        checkOutput("rstResTag",    64'(ifc.res_tag),    64'(0));
        checkOutput("rstResErr",    64'(ifc.res_err),    64'(0));

        // Directed vectors with hand-computed results and latency from an idle stage.
        applyStimulus(4'b0000, 4'b0000, 32'h0000_0001, 32'h0000_0016, 4'd1,
                      '{lo: 32'h0000_0017, hi: 32'h0, flags: 4'b0000}, 1'b0, 2);
        waitDrain();
        applyStimulus(4'b0000, 4'b0000, 32'h0000_ABCD, 32'h7FFF_FFFF, 4'd2,
                      '{lo: 32'h8000_ABCC, hi: 32'h0, flags: 4'b0101}, 1'b0, 2);
        waitDrain();
        applyStimulus(4'b0011, 4'b0000, 32'h4000_0000, 32'h0000_0008, 4'd3,
                      '{lo: 32'h0, hi: 32'h0000_0002, flags: 4'b0100}, 1'b0, 5);
        waitDrain();
        checkOutput("aluHoldOp",  64'(ifc.alu_op),  64'(4'b0011));
        checkOutput("aluHoldIn0", 64'(ifc.alu_in0), 64'(32'h4000_0000));

        applyStimulus(4'b0101, 4'b0000, 32'h1234_5678, 32'h0F0F_0F0F, 4'd4,
                      '{lo: 32'h0, hi: 32'h0, flags: 4'h0}, 1'b1, 2);
        applyModelCmd(4'b0010, 4'b0010, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd5);
        waitDrain();

        // Backpressure: one command parks in RESP, four fill the FIFO.
        ifc.res_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            applyModelCmd(4'b0000, 4'b0001, 32'(i * 32'h111), 32'(i * 3), 4'(i + 6));
        checkOutput("bpFifoCount", 64'(ifc.fifo_count), 64'(4));
        checkOutput("bpCmdReady",  64'(ifc.cmd_ready),  64'(0));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bpStillFull", 64'(ifc.cmd_ready),  64'(0));
        checkOutput("bpBusy",      64'(ifc.busy),       64'(1));
        ifc.res_ready = 1'b1;
        applyModelCmd(4'b0001, 4'b0000, 32'h0000_0003, 32'h0000_0004, 4'd11);
        waitDrain();
        checkOutput("bpReadyBack", 64'(ifc.cmd_ready),  64'(1));
        checkOutput("bpEmpty",     64'(ifc.fifo_count), 64'(0));

        // Random mix with random downstream stalls.
        fork
            begin
                int guard;
                guard = 0;
                while (!pushDone && guard < 5000) begin
                    @(posedge clk); #1;
                    ifc.res_ready = 1'($urandom_range(0, 1));
                    guard++;
                end
                ifc.res_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [3:0] op;
                    op = (i % 7 == 6) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
                    applyModelCmd(op, 4'($urandom_range(0, 3)), $urandom, $urandom, 4'(i));
                end
                pushDone = 1'b1;
            end
        join
        waitDrain();

        // Reset during a multiply with two commands queued behind it.
        applyModelCmd(4'b0011, 4'b0000, 32'h0001_0000, 32'h0001_0000, 4'd12);
        applyModelCmd(4'b0000, 4'b0000, 32'h5, 32'h6, 4'd13);
        applyModelCmd(4'b0000, 4'b0000, 32'h7, 32'h8, 4'd14);
        checkOutput("preRstCount", 64'(ifc.fifo_count), 64'(2));
        checkOutput("preRstBusy",  64'(ifc.busy),       64'(1));
        #2 rst_n = 1'b0;
        sbq.delete();
        #1;
        checkOutput("midRstResValid",  64'(ifc.res_valid),  64'(0));
        checkOutput("midRstFifoCount", 64'(ifc.fifo_count), 64'(0));
        checkOutput("midRstBusy",      64'(ifc.busy),       64'(0));
        checkOutput("midRstAluOp",     64'(ifc.alu_op),     64'(0));
        checkOutput("midRstAluIn0",    64'(ifc.alu_in0),    64'(0));
        checkOutput("midRstAluIn1",    64'(ifc.alu_in1),    64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("noStale", 64'(ifc.res_valid), 64'(0));
        end
        @(posedge clk); #1;
        applyStimulus(4'b0000, 4'b0000, 32'h0000_0001, 32'h0000_0016, 4'd15,
                      '{lo: 32'h0000_0017, hi: 32'h0, flags: 4'b0000}, 1'b0, 2);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
